// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetch/decode/issue controller driving the alu datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            init,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [3:0]      op,
  output logic [2:0]      op1,
  output logic [2:0]      op2,
  output logic            exec,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_z,
  output logic            flag_c,
  output logic            flag_v,
  output logic            flag_z,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  // 1110 decodes as neither load nor store, so it is safe to present while idle
  localparam logic [3:0] OP_IDLE = 4'hE;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic            flag_c_q, flag_v_q, flag_z_q;
  logic [3:0]      op_q;
  logic [2:0]      op1_q, op2_q;
  logic            exec_q;

  logic [3:0]      ir_op_d;
  logic [PC_W-1:0] pc_inc_d;
  logic [PC_W-1:0] target_d;

  assign ir_op_d  = ir_q[15:12];
  assign pc_inc_d = pc_q + PC_W'(1);
  assign target_d = ir_q[PC_W-1:0];

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b0;
      op_q     <= OP_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      exec_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_q     <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_z_q <= 1'b0;
            state_q  <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          unique case (ir_op_d)
            OP_JMP: begin
              pc_q    <= target_d;
              state_q <= S_FETCH;
            end
            OP_BZ: begin
              pc_q    <= flag_z_q ? target_d : pc_inc_d;
              state_q <= S_FETCH;
            end
            OP_NOP: begin
              pc_q    <= pc_inc_d;
              state_q <= S_FETCH;
            end
            OP_HALT: begin
              state_q <= S_HALTED;
            end
            default: begin
              // Issue fields are registered here so they are stable for all of EXEC
              op_q    <= ir_op_d;
              op1_q   <= ir_q[11:9];
              op2_q   <= ir_q[8:6];
              exec_q  <= 1'b1;
              state_q <= S_EXEC;
            end
          endcase
        end

        S_EXEC: begin
          unique case (ir_op_d)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              flag_c_q <= alu_c;
              flag_v_q <= alu_v;
              flag_z_q <= alu_z;
            end
            4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
              flag_z_q <= alu_z;
            end
            default: begin
            end
          endcase
          op_q    <= OP_IDLE;
          op1_q   <= '0;
          op2_q   <= '0;
          exec_q  <= 1'b0;
          pc_q    <= pc_inc_d;
          state_q <= S_FETCH;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALTED);
  assign op        = op_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign exec      = exec_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign flag_z    = flag_z_q;
  assign pc        = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : directed bench with an issue scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } iss_t;

  logic        clk = 1'b0;
  logic        init;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [3:0]  op;
  logic [2:0]  op1, op2;
  logic        exec;
  logic        alu_c, alu_v, alu_z;
  logic        flag_c, flag_v, flag_z;
  logic [7:0]  pc;
  logic        busy, halted;

  logic [15:0] mem [256];
  iss_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8)) dut (
    .clk(clk), .init(init), .start(start),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .op(op), .op1(op1), .op2(op2), .exec(exec),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
    .pc(pc), .busy(busy), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic c, input logic v, input logic z);
    alu_c = c; alu_v = v; alu_z = z;
  endtask

  // Issue monitor: every exec pulse must match the next queued expectation
  always @(negedge clk) begin
    if (exec === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_exec: got op=%0h op1=%0h op2=%0h expected no issue at %0t",
                 op, op1, op2, $time);
      end else begin
        iss_t e;
        e = exp_q.pop_front();
        if ({op, op1, op2} !== e) begin
          errors++;
          $display("FAIL issue: got op=%0h op1=%0h op2=%0h expected op=%0h op1=%0h op2=%0h",
                   op, op1, op2, e.op, e.a, e.b);
        end
      end
    end else if (init === 1'b0) begin
      checks++;
      if ({op, op1, op2} !== {4'hE, 3'd0, 3'd0}) begin
        errors++;
        $display("FAIL idle_issue: got op=%0h op1=%0h op2=%0h expected op=e op1=0 op2=0",
                 op, op1, op2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    mem[8'h00] = 16'h3280;  // ADD r1,r2
    mem[8'h01] = 16'hD020;  // BZ 0x20
    mem[8'h20] = 16'h7A40;  // logical op 7, r5,r1
    mem[8'h21] = 16'hD030;  // BZ 0x30 (not taken)
    mem[8'h22] = 16'hC0FF;  // JMP 0xFF
    mem[8'hFF] = 16'h5280;  // store r1,r2

    init = 1'b1; start = 1'b0; imem_valid = 1'b1;
    set_alu(1'b0, 1'b0, 1'b0);
    step(); step();

    chk("rst_pc", pc, 0);
    chk("rst_flags", {flag_c, flag_v, flag_z}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_exec", exec, 0);
    chk("rst_op", op, 4'hE);

    init = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Zero-wait ADD
    set_alu(1'b1, 1'b0, 1'b1);
    exp_q.push_back('{op: 4'h3, a: 3'd1, b: 3'd2});
    start = 1'b1;
    step();
    start = 1'b0;
    chk("add_fetch_req", imem_req, 1);
    chk("add_fetch_addr", imem_addr, 8'h00);
    chk("add_fetch_busy", busy, 1);
    step();
    chk("add_decode_exec", exec, 0);
    chk("add_decode_req", imem_req, 0);
    step();
    chk("add_exec", exec, 1);
    chk("add_op", op, 4'h3);
    step();
    chk("add_pc", pc, 8'h01);
    chk("add_flags_cvz", {flag_c, flag_v, flag_z}, 3'b101);

    // BZ taken
    step(); step();
    chk("bz_taken_pc", pc, 8'h20);

    // Logical op: only Z follows the ALU; start while busy is ignored
    set_alu(1'b0, 1'b1, 1'b0);
    exp_q.push_back('{op: 4'h7, a: 3'd5, b: 3'd1});
    start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    chk("logic_pc", pc, 8'h21);
    chk("logic_flags_cvz", {flag_c, flag_v, flag_z}, 3'b100);
    chk("start_busy_ignored", busy, 1);

    // BZ not taken, then JMP
    step(); step();
    chk("bz_not_taken_pc", pc, 8'h22);
    step(); step();
    chk("jmp_pc", pc, 8'hFF);

    // Store at 0xFF: no flag change, pc wraps
    set_alu(1'b0, 1'b1, 1'b1);
    exp_q.push_back('{op: 4'h5, a: 3'd1, b: 3'd2});
    step();
    step();
    chk("store_exec", exec, 1);
    imem_valid = 1'b0;
    mem[8'h00] = 16'h1A00;  // DEC r5
    mem[8'h01] = 16'hE000;  // NOP
    mem[8'h02] = 16'hF000;  // HALT
    step();
    chk("wrap_pc", pc, 8'h00);
    chk("store_flags_cvz", {flag_c, flag_v, flag_z}, 3'b100);

    // Wait states
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 8'h00);
      step();
    end
    set_alu(1'b0, 1'b1, 1'b0);
    exp_q.push_back('{op: 4'h1, a: 3'd5, b: 3'd0});
    imem_valid = 1'b1;
    step();
    chk("wait_decode_exec", exec, 0);
    step();
    chk("wait_issue", exec, 1);
    step();
    chk("dec_flags_cvz", {flag_c, flag_v, flag_z}, 3'b010);
    chk("dec_pc", pc, 8'h01);

    // NOP, HALT
    step(); step();
    chk("nop_pc", pc, 8'h02);
    step(); step();
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_op", op, 4'hE);
    chk("halt_pc", pc, 8'h02);
    step();
    chk("halt_stays", halted, 1);

    // Restart from HALTED
    mem[8'h00] = 16'h3280;  // ADD r1,r2
    mem[8'h01] = 16'h0000;  // INC r0
    set_alu(1'b1, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", pc, 8'h00);
    chk("restart_flags_cvz", {flag_c, flag_v, flag_z}, 3'b000);
    chk("restart_busy", busy, 1);
    chk("restart_halted", halted, 0);
    exp_q.push_back('{op: 4'h3, a: 3'd1, b: 3'd2});
    step(); step(); step();
    chk("restart_add_flags", {flag_c, flag_v, flag_z}, 3'b101);

    // Reset in the middle of EXEC
    step(); step();
    chk("inc_exec", exec, 1);
    #2;
    init = 1'b1;
    #1;
    chk("midrst_exec", exec, 0);
    chk("midrst_op", op, 4'hE);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_flags", {flag_c, flag_v, flag_z}, 3'b000);
    chk("midrst_busy", busy, 0);
    chk("midrst_req", imem_req, 0);
    step();
    init = 1'b0;
    step(); step();
    chk("issues_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
